// File: rtl/color_remap_pkg.sv
// Shared types and constants for the colour remapper.
package color_remap_pkg;

   localparam int DEFAULT_RGB_W = 8;

   typedef logic [DEFAULT_RGB_W-1:0] rgb_t;

   typedef struct packed {
      logic valid;
      logic blink;
      rgb_t from;
      rgb_t to;
   } remap_entry_t;

   localparam rgb_t TRANSPARENT_COLOR = 8'hFF;

endpackage

// File: rtl/color_remap_blink_timer.sv
// Frame-counted blink phase generator; compiled only when COLOR_REMAP_BLINK_EN is defined.
// blink_phase toggles every BLINK_FRAMES startOfFrame pulses and resets to 1 (on).
`ifdef COLOR_REMAP_BLINK_EN
module color_remap_blink_timer #(
   parameter int BLINK_FRAMES = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic startOfFrame,
   output logic blink_phase
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (startOfFrame) begin
         if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign blink_phase = phase_q;

endmodule
`endif

// File: rtl/color_remapper.sv
// Programmable from->to pixel colour substitution table with registered output.
// Define COLOR_REMAP_BLINK_EN to add per-entry blinking driven by a frame timer.
module color_remapper
   import color_remap_pkg::*;
#(
   parameter  int NUM_ENTRIES  = 4,
   parameter  int RGB_W        = 8,
   parameter  int BLINK_FRAMES = 15,
   localparam int IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startOfFrame,
   input  logic             enable,
   input  logic [RGB_W-1:0] RGBin,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_valid,
   input  logic             wr_blink,
   input  logic [RGB_W-1:0] wr_from,
   input  logic [RGB_W-1:0] wr_to,
   input  logic             clear_all,
   output logic [RGB_W-1:0] RGBout,
   output logic             hit,
   output logic             blink_phase
);

   logic [NUM_ENTRIES-1:0]            valid_q, valid_d;
   logic [NUM_ENTRIES-1:0][RGB_W-1:0] from_q, from_d;
   logic [NUM_ENTRIES-1:0][RGB_W-1:0] to_q, to_d;
   logic [RGB_W-1:0]                  rgb_q, rgb_d;
   logic                              hit_q, hit_d;
   logic                              found;
   logic [RGB_W-1:0]                  sel;

`ifdef COLOR_REMAP_BLINK_EN
   logic [NUM_ENTRIES-1:0] blink_q, blink_d;

   color_remap_blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink_timer (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .blink_phase  (blink_phase)
   );
`else
   logic unused_blink;
   assign unused_blink = ^{startOfFrame, wr_blink};
   assign blink_phase  = 1'b1;
`endif

   // Out-of-range wr_idx matches no entry, so such writes fall through untouched.
   always_comb begin
      valid_d = valid_q;
      from_d  = from_q;
      to_d    = to_q;
`ifdef COLOR_REMAP_BLINK_EN
      blink_d = blink_q;
`endif
      if (clear_all) begin
         valid_d = '0;
`ifdef COLOR_REMAP_BLINK_EN
         blink_d = '0;
`endif
      end else if (wr_en) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               valid_d[i] = wr_valid;
               from_d[i]  = wr_from;
               to_d[i]    = wr_to;
`ifdef COLOR_REMAP_BLINK_EN
               blink_d[i] = wr_blink;
`endif
            end
         end
      end
   end

   // Lowest active index wins; the table is read from registers, so writes never bypass.
   always_comb begin
      logic act;
      act   = 1'b0;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef COLOR_REMAP_BLINK_EN
         act = valid_q[i] && (from_q[i] == RGBin) && (!blink_q[i] || blink_phase);
`else
         act = valid_q[i] && (from_q[i] == RGBin);
`endif
         if (act && !found) begin
            found = 1'b1;
            sel   = to_q[i];
         end
      end
      hit_d = enable && found;
      rgb_d = hit_d ? sel : RGBin;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         rgb_q   <= '0;
         hit_q   <= 1'b0;
`ifdef COLOR_REMAP_BLINK_EN
         blink_q <= '0;
`endif
      end else begin
         valid_q <= valid_d;
         rgb_q   <= rgb_d;
         hit_q   <= hit_d;
`ifdef COLOR_REMAP_BLINK_EN
         blink_q <= blink_d;
`endif
      end
   end

   // Colour fields are qualified by valid, so they carry no reset.
   always_ff @(posedge clk) begin
      from_q <= from_d;
      to_q   <= to_d;
   end

   assign RGBout = rgb_q;
   assign hit    = hit_q;

endmodule
